fsk_demodulate: RTL and testbench

- Recovers the data bit stream from a two-tone FSK square wave produced by the team's FSK modulator.
- Measures the interval between wave edges and classifies each interval as high tone (bit 1) or low tone (bit 0).
- Majority-votes the classifications over each symbol window and emits one bit per symbol with a valid strobe and an error flag.
- Sits at the receive end of the channel path, feeding the downstream decoder.

---
 rtl/fsk_pkg.sv | 31 +++
 rtl/fsk_edge_timer.sv | 63 ++++++
 rtl/fsk_demodulate.sv | 158 +++++++++++++++
 tb/tb_fsk_demodulate.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fsk_pkg.sv
// Definitions shared by the FSK modulator and demodulator: FSM state encoding,
// the default tone/symbol timing both ends must agree on, and a tolerance-band helper.
package fsk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2
    } fsk_state_e;

    localparam int unsigned FSK_HALF_H  = 32'd4;
    localparam int unsigned FSK_HALF_L  = 32'd8;
    localparam int unsigned FSK_TOL     = 32'd1;
    localparam int unsigned FSK_SYM_LEN = 32'd32;

    // True when |val - centre| <= tol; evaluated one bit wider so nothing wraps.
    function automatic logic in_band(
        input logic [15:0] val,
        input logic [15:0] centre,
        input logic [15:0] tol
    );
        logic [16:0] val_w;
        logic [16:0] centre_w;
        logic [16:0] tol_w;
        val_w    = {1'b0, val};
        centre_w = {1'b0, centre};
        tol_w    = {1'b0, tol};
        in_band  = ((val_w + tol_w) >= centre_w) && (val_w <= (centre_w + tol_w));
    endfunction

endpackage

// File: rtl/fsk_edge_timer.sv
// Synchronises a square wave, detects edges of either polarity and classifies the
// interval between consecutive edges as a high-tone or low-tone half-period.
module fsk_edge_timer
    import fsk_pkg::*;
#(
    parameter int unsigned HALF_H = FSK_HALF_H,
    parameter int unsigned HALF_L = FSK_HALF_L,
    parameter int unsigned TOL    = FSK_TOL,
    parameter int unsigned CW     = $clog2(HALF_L + TOL + 2)
) (
    input  logic clk,
    input  logic rst,
    input  logic wave_in,
    output logic edge_det,
    output logic vote_h,
    output logic vote_l,
    output logic timeout
);

    localparam logic [CW-1:0] CNT_SAT = CW'(HALF_L + TOL + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(32'd1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   cnt_ext_s;

    // Edge detect, classification of the interval ending on this edge, and counter update.
    always_comb begin
        sync1_d   = wave_in;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        edge_det  = sync2_q ^ prev_q;
        timeout   = (cnt_q == CNT_SAT);
        cnt_ext_s = 16'(cnt_q);
        vote_h    = edge_det && in_band(cnt_ext_s, 16'(HALF_H), 16'(TOL));
        vote_l    = edge_det && in_band(cnt_ext_s, 16'(HALF_L), 16'(TOL));
        if (edge_det) begin
            cnt_d = CNT_ONE;
        end else if (timeout) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Synchroniser, edge register and interval counter state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            cnt_q   <= {CW{1'b0}};
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/fsk_demodulate.sv
// Two-tone FSK receiver: majority-votes edge-interval classifications over each
// symbol window and emits one decided bit per symbol with an undecidable flag.
module fsk_demodulate
    import fsk_pkg::*;
#(
    parameter int unsigned HALF_H  = FSK_HALF_H,
    parameter int unsigned HALF_L  = FSK_HALF_L,
    parameter int unsigned TOL     = FSK_TOL,
    parameter int unsigned SYM_LEN = FSK_SYM_LEN,
    parameter int unsigned CW      = $clog2(HALF_L + TOL + 2)
) (
    input  logic clk,
    input  logic rst,
    input  logic wave_in,
    input  logic sig_valid,
    output logic bit_out,
    output logic bit_valid,
    output logic bit_err,
    output logic carrier_ok
);

    localparam int unsigned   SW       = $clog2(SYM_LEN);
    localparam int unsigned   VW       = $clog2(SYM_LEN) + 1;
    localparam logic [SW-1:0] SYM_LAST = SW'(SYM_LEN - 1);
    localparam logic [SW-1:0] SYM_ONE  = SW'(32'd1);

    fsk_state_e    state_q, state_d;
    logic [SW-1:0] sym_q, sym_d;
    logic [VW-1:0] hv_q, hv_d, lv_q, lv_d;
    logic [VW-1:0] hv_sum_s, lv_sum_s;
    logic          bit_out_q, bit_out_d;
    logic          bit_valid_q, bit_valid_d;
    logic          bit_err_q, bit_err_d;
    logic          carrier_q, carrier_d;
    logic          edge_s, vote_h_s, vote_l_s, timeout_s;

    fsk_edge_timer #(
        .HALF_H (HALF_H),
        .HALF_L (HALF_L),
        .TOL    (TOL),
        .CW     (CW)
    ) u_edge_timer (
        .clk      (clk),
        .rst      (rst),
        .wave_in  (wave_in),
        .edge_det (edge_s),
        .vote_h   (vote_h_s),
        .vote_l   (vote_l_s),
        .timeout  (timeout_s)
    );

    // Next-state logic; tallies include a vote landing on the decision cycle itself.
    always_comb begin
        state_d     = state_q;
        sym_d       = sym_q;
        hv_d        = hv_q;
        lv_d        = lv_q;
        bit_out_d   = bit_out_q;
        bit_valid_d = 1'b0;
        bit_err_d   = bit_err_q;
        carrier_d   = carrier_q;
        hv_sum_s    = hv_q + {{(VW-1){1'b0}}, vote_h_s};
        lv_sum_s    = lv_q + {{(VW-1){1'b0}}, vote_l_s};
        case (state_q)
            ST_IDLE: begin
                carrier_d = 1'b0;
                if (sig_valid) begin
                    state_d = ST_ACQUIRE;
                    sym_d   = {SW{1'b0}};
                    hv_d    = {VW{1'b0}};
                    lv_d    = {VW{1'b0}};
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACQUIRE: begin
                if (timeout_s) begin
                    carrier_d = 1'b0;
                end else begin
                    carrier_d = carrier_q;
                end
                if (!sig_valid) begin
                    state_d = ST_IDLE;
                end else if (edge_s) begin
                    state_d = ST_TRACK;
                    sym_d   = {SW{1'b0}};
                end else begin
                    state_d = ST_ACQUIRE;
                end
            end
            ST_TRACK: begin
                if (timeout_s) begin
                    carrier_d = 1'b0;
                end else if (vote_h_s || vote_l_s) begin
                    carrier_d = 1'b1;
                end else begin
                    carrier_d = carrier_q;
                end
                if (!sig_valid) begin
                    state_d = ST_IDLE;
                end else if (sym_q == SYM_LAST) begin
                    bit_valid_d = 1'b1;
                    sym_d       = {SW{1'b0}};
                    hv_d        = {VW{1'b0}};
                    lv_d        = {VW{1'b0}};
                    if (hv_sum_s > lv_sum_s) begin
                        bit_out_d = 1'b1;
                        bit_err_d = 1'b0;
                    end else if (lv_sum_s > hv_sum_s) begin
                        bit_out_d = 1'b0;
                        bit_err_d = 1'b0;
                    end else begin
                        bit_out_d = bit_out_q;
                        bit_err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_TRACK;
                    sym_d   = sym_q + SYM_ONE;
                    hv_d    = hv_sum_s;
                    lv_d    = lv_sum_s;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                carrier_d = 1'b0;
            end
        endcase
    end

    // Control FSM state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            sym_q       <= {SW{1'b0}};
            hv_q        <= {VW{1'b0}};
            lv_q        <= {VW{1'b0}};
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            bit_err_q   <= 1'b0;
            carrier_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sym_q       <= sym_d;
            hv_q        <= hv_d;
            lv_q        <= lv_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            bit_err_q   <= bit_err_d;
            carrier_q   <= carrier_d;
        end
    end

    assign bit_out    = bit_out_q;
    assign bit_valid  = bit_valid_q;
    assign bit_err    = bit_err_q;
    assign carrier_ok = carrier_q;

endmodule

// File: tb/tb_fsk_demodulate.sv
// Scoreboard bench for fsk_demodulate: frames of tone half-periods are turned into
// edge times, a reference model derives the expected bits and carrier state from them.
module tb_fsk_demodulate;

    localparam int HH       = 4;
    localparam int HL       = 8;
    localparam int TL       = 1;
    localparam int SL       = 32;
    localparam int SAT      = HL + TL + 1;
    localparam int T0       = 4;
    localparam int EDGE_LAT = 3;

    typedef struct {
        int cyc;
        int b;
        int e;
    } exp_t;

    logic clk       = 1'b0;
    logic rst       = 1'b0;
    logic wave_in   = 1'b0;
    logic sig_valid = 1'b0;
    logic bit_out;
    logic bit_valid;
    logic bit_err;
    logic carrier_ok;

    int   cyc        = 0;
    int   total      = 0;
    int   bad        = 0;
    int   model_prev = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    int   hr[8];

    fsk_demodulate #(
        .HALF_H  (HH),
        .HALF_L  (HL),
        .TOL     (TL),
        .SYM_LEN (SL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wave_in    (wave_in),
        .sig_valid  (sig_valid),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .bit_err    (bit_err),
        .carrier_ok (carrier_ok)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // 1 = high-tone vote, 2 = low-tone vote, 0 = no vote
    function automatic int vote_of(input int d);
        if (d >= HH - TL && d <= HH + TL) return 1;
        if (d >= HL - TL && d <= HL + TL) return 2;
        return 0;
    endfunction

    // Carrier state after clock edge q, given the clock edges at which wave edges are seen.
    function automatic int carrier_at(input int q, input int e[$]);
        int c;
        int last;
        int seen;
        c    = 0;
        last = 0;
        seen = 0;
        for (int i = 0; i < e.size(); i++) begin
            if (e[i] > q) break;
            if (i > 0) begin
                if (e[i] - e[i-1] >= SAT) c = 0;
                else if (vote_of(e[i] - e[i-1]) != 0) c = 1;
            end
            last = e[i];
            seen = 1;
        end
        if (seen != 0 && q - last >= SAT) c = 0;
        return c;
    endfunction

    // Monitor: every bit_valid pops one expectation; overdue expectations are misses.
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            total++;
            bad++;
            $display("FAIL missed_bit: no bit_valid, expected at cycle %0d, now %0d", sb_q[0].cyc, cyc);
            void'(sb_q.pop_front());
        end
        if (bit_valid) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_bit_valid: bit_valid=1 with nothing expected at cycle %0d", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("bit_time", cyc, mon_e.cyc);
                chk("bit_out", int'(bit_out), mon_e.b);
                chk("bit_err", int'(bit_err), mon_e.e);
            end
        end
    end

    // abort_kind: 0 none, 1 drop sig_valid at symbol count 20 of symbol abort_k,
    // 2 pull rst low at symbol count 15 of symbol abort_k
    task automatic run_frame(input int nsym, input int hps[8], input int abort_k, input int abort_kind);
        int   t[$];
        int   e[$];
        int   c0, cur, k, hp, lim, r_stop, ti, hv, lv, v, nemit;
        exp_t ent;
        @(negedge clk);
        c0  = cyc;
        lim = T0 + SL * nsym;
        t.push_back(T0);
        cur = T0;
        while (1) begin
            k = (cur - T0) / SL;
            if (k >= nsym) break;
            hp = hps[k];
            if (hp == 0) begin
                cur = T0 + SL * (k + 1);
            end else begin
                cur += hp;
                if (cur > lim) break;
                t.push_back(cur);
            end
        end
        foreach (t[i]) e.push_back(c0 + t[i] + EDGE_LAT);

        nemit = (abort_kind == 0) ? nsym : abort_k;
        for (int s = 0; s < nemit; s++) begin
            hv = 0;
            lv = 0;
            for (int i = 1; i < e.size(); i++) begin
                if (e[i] >= e[0] + 1 + SL * s && e[i] <= e[0] + SL * (s + 1)) begin
                    v = vote_of(e[i] - e[i-1]);
                    if (v == 1) hv++;
                    else if (v == 2) lv++;
                end
            end
            ent.cyc = e[0] + SL * (s + 1);
            if (hv > lv) begin
                ent.b = 1;
                ent.e = 0;
            end else if (lv > hv) begin
                ent.b = 0;
                ent.e = 0;
            end else begin
                ent.b = model_prev;
                ent.e = 1;
            end
            model_prev = ent.b;
            sb_q.push_back(ent);
        end

        r_stop = (abort_kind == 1) ? 27 + SL * abort_k :
                 (abort_kind == 2) ? 22 + SL * abort_k : lim + 8;
        ti = 0;
        for (int r = 0; r <= r_stop; r++) begin
            chk("carrier_ok", int'(carrier_ok), carrier_at(c0 + r, e));
            if (r == r_stop) break;
            sig_valid = 1'b1;
            if (ti < t.size() && t[ti] == r) begin
                wave_in = ~wave_in;
                ti++;
            end
            @(negedge clk);
        end

        if (abort_kind == 2) begin
            rst = 1'b0;
            #1;
            chk("rst_bit_out", int'(bit_out), 0);
            chk("rst_bit_valid", int'(bit_valid), 0);
            chk("rst_bit_err", int'(bit_err), 0);
            chk("rst_carrier_ok", int'(carrier_ok), 0);
            model_prev = 0;
            sig_valid  = 1'b0;
            repeat (3) @(negedge clk);
            rst = 1'b1;
        end else begin
            sig_valid = 1'b0;
        end
        repeat (16) @(negedge clk);
        chk("carrier_idle", int'(carrier_ok), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("reset_bit_out", int'(bit_out), 0);
        chk("reset_bit_valid", int'(bit_valid), 0);
        chk("reset_bit_err", int'(bit_err), 0);
        chk("reset_carrier_ok", int'(carrier_ok), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (16) @(negedge clk);

        run_frame(4, '{4, 4, 4, 4, 0, 0, 0, 0}, 0, 0);
        run_frame(4, '{4, 8, 4, 4, 0, 0, 0, 0}, 0, 0);
        run_frame(4, '{5, 7, 6, 6, 0, 0, 0, 0}, 0, 0);
        run_frame(4, '{4, 4, 0, 0, 0, 0, 0, 0}, 0, 0);
        run_frame(4, '{4, 4, 4, 4, 0, 0, 0, 0}, 2, 1);
        run_frame(2, '{8, 8, 0, 0, 0, 0, 0, 0}, 0, 0);
        run_frame(3, '{8, 8, 8, 0, 0, 0, 0, 0}, 1, 2);
        run_frame(2, '{4, 8, 0, 0, 0, 0, 0, 0}, 0, 0);

        for (int f = 0; f < 12; f++) begin
            for (int i = 0; i < 8; i++) begin
                hr[i] = int'($urandom_range(0, 11));
                if (hr[i] == 1) hr[i] = HH;
            end
            run_frame(int'($urandom_range(2, 5)), hr, 0, 0);
        end

        repeat (40) @(negedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
